// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution stream controller.
// The optional drain watchdog (CONV_CTRL_TIMEOUT_EN) uses DRAIN_TIMEOUT.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_FILTER = 3'd1,
        STREAM      = 3'd2,
        DRAIN       = 3'd3,
        DONE        = 3'd4
    } ctrl_state_t;

    localparam logic [15:0] DRAIN_TIMEOUT = 16'hFFFF;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_out_coord_counter.sv
// Row/column tracker for output results: column advances first, wraps at
// SIDE-1 and bumps the row. Holds at the final coordinate; 'last' flags it.
module conv_out_coord_counter
    import conv_ctrl_pkg::*;
#(
    parameter int SIDE = 9,
    parameter int CW   = safe_clog2(SIDE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(SIDE - 1);

    assign last = (row == MAX) && (col == MAX);

    // Advance the coordinate on each accepted result; clear at job start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance && !last) begin
            if (col == MAX) begin
                col <= '0;
                row <= row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_stream_controller.sv
// Sequences one convolution job: load filter weights, stream image pixels,
// then drain until every output dot product has returned. Results are tagged
// with their output row/column.
// Optional macro CONV_CTRL_TIMEOUT_EN adds a drain watchdog and a sticky
// 'timeout' output.
//
// Handshakes: a word moves when valid && ready are both high at a rising
// clock edge; ready depends only on the controller state, never on valid.
module conv_stream_controller
    import conv_ctrl_pkg::*;
#(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic [bitwidth-1:0] filt_data,
    input  logic                filt_valid,
    output logic                filt_ready,
    input  logic [bitwidth-1:0] pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [bitwidth-1:0] data_out,
    output logic                isValid_out,
    output logic [bitwidth-1:0] filter_out,
    output logic                filterLoad_out,
    input  logic [31:0]         dotproduct_in,
    input  logic                dotproductReady_in,
    output logic [31:0]         result_data,
    output logic                result_valid,
    output logic [safe_clog2(imageWidth-filterWidth+1)-1:0] result_row,
    output logic [safe_clog2(imageWidth-filterWidth+1)-1:0] result_col,
    output logic [2:0]          state,
`ifdef CONV_CTRL_TIMEOUT_EN
    output logic                timeout,
`endif
    output logic                overflow
);

    localparam int filterSize = filterWidth * filterWidth;
    localparam int imageSize  = imageWidth * imageWidth;
    localparam int outWidth   = imageWidth - filterWidth + 1;
    localparam int outSize    = outWidth * outWidth;

    localparam int CW  = safe_clog2(outWidth);
    localparam int WCW = safe_clog2(filterSize + 1);
    localparam int PCW = safe_clog2(imageSize + 1);
    localparam int RCW = safe_clog2(outSize + 1);

    localparam logic [WCW-1:0] W_LAST = WCW'(filterSize - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(imageSize - 1);
    localparam logic [RCW-1:0] OS_C   = RCW'(outSize);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LOAD   = LOAD_FILTER;
    localparam logic [2:0] S_STREAM = STREAM;
    localparam logic [2:0] S_DRAIN  = DRAIN;
    localparam logic [2:0] S_DONE   = DONE;

    logic [WCW-1:0] wcnt;
    logic [PCW-1:0] pcnt;
    logic [RCW-1:0] rcnt;
    logic [RCW-1:0] rcnt_next;
    logic           w_take, p_take, r_take, r_drop, job_start;
    logic [CW-1:0]  coord_row, coord_col;
    logic           coord_last;
    logic           wd_expired;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign filt_ready = (state == S_LOAD);
    assign pix_ready  = (state == S_STREAM);

    assign job_start = (state == S_IDLE) && start;
    assign w_take    = filt_valid && filt_ready;
    assign p_take    = pix_valid && pix_ready;
    assign r_take    = dotproductReady_in && (rcnt < OS_C) &&
                       ((state == S_STREAM) || (state == S_DRAIN));
    assign r_drop    = dotproductReady_in && !r_take;
    // A result landing with the last pixel still counts towards completion.
    assign rcnt_next = rcnt + RCW'(r_take);

`ifdef CONV_CTRL_TIMEOUT_EN
    logic [15:0] wd;
    assign wd_expired = (state == S_DRAIN) && (wd == DRAIN_TIMEOUT) && !r_take;

    // Drain watchdog: idle at zero outside DRAIN, restarts on every result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            if (state != S_DRAIN || r_take) begin
                wd <= '0;
            end else if (wd != DRAIN_TIMEOUT) begin
                wd <= wd + 16'd1;
            end
            if (job_start) begin
                timeout <= 1'b0;
            end else if (wd_expired && rcnt != OS_C) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Job sequencing and weight/pixel counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt  <= '0;
            pcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        wcnt  <= '0;
                        pcnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_take) begin
                        wcnt <= wcnt + WCW'(1);
                        if (wcnt == W_LAST) state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (p_take) begin
                        pcnt <= pcnt + PCW'(1);
                        if (pcnt == P_LAST) state <= (rcnt_next == OS_C) ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rcnt == OS_C || wd_expired) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register accepted weights and pixels toward the datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filter_out     <= '0;
            filterLoad_out <= 1'b0;
            data_out       <= '0;
            isValid_out    <= 1'b0;
        end else begin
            filterLoad_out <= w_take;
            isValid_out    <= p_take;
            if (w_take) filter_out <= filt_data;
            if (p_take) data_out <= pix_data;
        end
    end

    // Capture and tag returned results; flag any result that cannot be taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_data  <= '0;
            result_valid <= 1'b0;
            result_row   <= '0;
            result_col   <= '0;
            rcnt         <= '0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= r_take;
            if (r_take) begin
                result_data <= dotproduct_in;
                result_row  <= coord_row;
                result_col  <= coord_col;
                rcnt        <= rcnt + RCW'(1);
            end
            if (job_start) begin
                rcnt     <= '0;
                overflow <= 1'b0;
            end
            if (r_drop) overflow <= 1'b1;
        end
    end

    conv_out_coord_counter #(
        .SIDE (outWidth),
        .CW   (CW)
    ) u_coord (
        .clock   (clock),
        .reset   (reset),
        .clear   (job_start),
        .advance (r_take),
        .row     (coord_row),
        .col     (coord_col),
        .last    (coord_last)
    );

    // The coordinate tracker and the result count must stay in lockstep.
    a_coord_sync: assert property (@(posedge clock) disable iff (reset)
        (r_take && coord_last) |-> (rcnt == OS_C - RCW'(1)));

endmodule

// File: tb/tb_conv_stream_controller.sv
// Bench for conv_stream_controller: a constant table of short IDLE/LOAD
// sequences, then whole jobs under several stimulus patterns compared against
// a count-based job model with an expected-result queue.
module tb_conv_stream_controller;
    import conv_ctrl_pkg::*;

    localparam int FS = 9;
    localparam int IS = 121;
    localparam int OW = 9;
    localparam int OS = 81;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [7:0]  filt_data = '0;
    logic        filt_valid = 1'b0;
    logic        filt_ready;
    logic [7:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  data_out, filter_out;
    logic        isValid_out, filterLoad_out;
    logic [31:0] dotproduct_in = '0;
    logic        dotproductReady_in = 1'b0;
    logic [31:0] result_data;
    logic        result_valid;
    logic [3:0]  result_row, result_col;
    logic [2:0]  state;
    logic        overflow;
`ifdef CONV_CTRL_TIMEOUT_EN
    logic        timeout;
`endif

    conv_stream_controller dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .filt_data(filt_data), .filt_valid(filt_valid), .filt_ready(filt_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .data_out(data_out), .isValid_out(isValid_out),
        .filter_out(filter_out), .filterLoad_out(filterLoad_out),
        .dotproduct_in(dotproduct_in), .dotproductReady_in(dotproductReady_in),
        .result_data(result_data), .result_valid(result_valid),
        .result_row(result_row), .result_col(result_col), .state(state),
`ifdef CONV_CTRL_TIMEOUT_EN
        .timeout(timeout),
`endif
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Job model: progress counts, sticky flags, expected held outputs.
    bit          active, done_now;
    int          w_acc, p_acc, r_acc, wd_m;
    logic        exp_ovf, exp_to;
    logic [7:0]  exp_filt, exp_pix;
    logic [31:0] exp_q[$];
    int          n_fload, n_valid, n_rvalid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        active = 0; done_now = 0; w_acc = 0; p_acc = 0; r_acc = 0; wd_m = 0;
        exp_ovf = 0; exp_to = 0; exp_filt = '0; exp_pix = '0; exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 0; filt_valid = 0; pix_valid = 0; dotproductReady_in = 0;
        filt_data = '0; pix_data = '0; dotproduct_in = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_filt_ready", filt_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_filterLoad", filterLoad_out, 0);
        check("rst_filter_out", filter_out, 0);
        check("rst_isValid", isValid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", result_data, 0);
        check("rst_row_col", {result_row, result_col}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", state, IDLE);
        model_clear();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict the edge, compare afterwards.
    task automatic tick(input logic st, input logic fv, input logic [7:0] fd,
                        input logic pv, input logic [7:0] pd,
                        input logic dr, input logic [31:0] dp);
        bit loading, streaming, last_pix, e_fload, e_valid, e_rvalid;
        int e_row, e_col, r_before;
        start = st; filt_valid = fv; filt_data = fd;
        pix_valid = pv; pix_data = pd; dotproductReady_in = dr; dotproduct_in = dp;
        loading   = active && !done_now && (w_acc < FS);
        streaming = active && !done_now && (w_acc == FS) && (p_acc < IS);
        check("busy", busy, active);
        check("filt_ready", filt_ready, loading);
        check("pix_ready", pix_ready, streaming);
        check("done", done, done_now);
        e_fload = 0; e_valid = 0; e_rvalid = 0; e_row = 0; e_col = 0; last_pix = 0;
        if (!active) begin
            if (st) begin
                active = 1; w_acc = 0; p_acc = 0; r_acc = 0; exp_ovf = 0; exp_to = 0;
            end
            if (dr) exp_ovf = 1;
        end else if (done_now) begin
            if (dr) exp_ovf = 1;
            active = 0; done_now = 0;
        end else if (loading) begin
            if (fv) begin w_acc++; e_fload = 1; exp_filt = fd; end
            if (dr) exp_ovf = 1;
        end else begin
            r_before = r_acc;
            if (streaming && pv) begin
                p_acc++; e_valid = 1; exp_pix = pd; last_pix = (p_acc == IS);
            end
            if (dr) begin
                if (r_acc < OS) begin
                    e_rvalid = 1; e_row = r_acc / OW; e_col = r_acc % OW;
                    exp_q.push_back(dp); r_acc++;
                end else begin
                    exp_ovf = 1;
                end
            end
            if (last_pix && r_acc == OS) done_now = 1;
            else if (!streaming && r_before == OS) done_now = 1;
`ifdef CONV_CTRL_TIMEOUT_EN
            else if (!streaming && !e_rvalid && wd_m == 65535) begin done_now = 1; exp_to = 1; end
`endif
            if (streaming || e_rvalid) wd_m = 0;
            else if (wd_m < 65535) wd_m++;
        end
        @(posedge clock); #1;
        check("filterLoad_out", filterLoad_out, e_fload);
        check("filter_out", filter_out, exp_filt);
        check("isValid_out", isValid_out, e_valid);
        check("data_out", data_out, exp_pix);
        check("result_valid", result_valid, e_rvalid);
        if (e_rvalid) begin
            check("result_data", result_data, exp_q.pop_front());
            check("result_row", result_row, e_row);
            check("result_col", result_col, e_col);
        end
        check("overflow", overflow, exp_ovf);
`ifdef CONV_CTRL_TIMEOUT_EN
        check("timeout", timeout, exp_to);
`endif
        n_fload += int'(e_fload); n_valid += int'(e_valid); n_rvalid += int'(e_rvalid);
    endtask

    // mode 0: back-to-back ordered data, results only after the last pixel
    // mode 1: pix_valid toggles, a result offered every cycle after loading
    // mode 2: random valids and result strobes
    // mode 3: no results at all (watchdog build only)
    task automatic run_job(input int mode, input int abort_pix);
        int cyc, prev_p;
        logic fv, pv, dr;
        logic [7:0] fd, pd;
        n_fload = 0; n_valid = 0; n_rvalid = 0;
        tick(1, 0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (active && cyc < 80000) begin
            if (abort_pix >= 0 && p_acc == abort_pix) break;
            fv = 1; pv = 1; dr = 0;
            fd = (mode == 0) ? 8'(w_acc + 1) : 8'($urandom);
            pd = (mode == 0) ? 8'(p_acc) : 8'($urandom);
            case (mode)
                0: dr = (w_acc == FS) && (p_acc == IS) && (r_acc < OS) && !done_now;
                1: begin pv = (cyc % 2 == 0); dr = (w_acc == FS); end
                2: begin
                    fv = 1'($urandom_range(0, 1));
                    pv = ($urandom_range(0, 3) != 0);
                    dr = ($urandom_range(0, 2) == 0);
                end
                default: ;
            endcase
            prev_p = p_acc;
            tick(0, fv, fd, pv, pd, dr, $urandom);
            if (mode == 0 && prev_p == IS - 1 && p_acc == IS)
                check("state_after_last_pixel", state, DRAIN);
            cyc++;
        end
        if (abort_pix < 0) begin
            check("job_finished_in_budget", active, 0);
            check("job_weight_count", n_fload, FS);
            check("job_pixel_count", n_valid, IS);
            check("job_result_count", n_rvalid, (mode == 3) ? 0 : OS);
            check("job_busy_low", busy, 0);
        end
    endtask

    typedef struct {
        logic st, fv, dr;
        logic [7:0] fd;
        logic exp_busy, exp_fload, exp_ovf;
        logic [7:0] exp_filt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // {start, filt_valid, result strobe, weight} -> {busy, filterLoad, overflow, filter_out}
        tbl[0] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00};
        tbl[1] = '{0, 0, 1, 8'h00, 0, 0, 1, 8'h00};
        tbl[2] = '{1, 0, 0, 8'h00, 1, 0, 0, 8'h00};
        tbl[3] = '{0, 1, 0, 8'h11, 1, 1, 0, 8'h11};
        tbl[4] = '{0, 0, 0, 8'h77, 1, 0, 0, 8'h11};
        tbl[5] = '{0, 1, 0, 8'hA5, 1, 1, 0, 8'hA5};
        tbl[6] = '{0, 0, 1, 8'h00, 1, 0, 1, 8'hA5};
        tbl[7] = '{1, 1, 0, 8'h3C, 1, 1, 1, 8'h3C};

        #1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].st, tbl[i].fv, tbl[i].fd, 0, 8'h00, tbl[i].dr, 32'h1234);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_filterLoad", i), filterLoad_out, tbl[i].exp_fload);
            check($sformatf("tbl%0d_filter_out", i), filter_out, tbl[i].exp_filt);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
        end
        do_reset();

        run_job(0, -1);
        // A result strobe while idle is dropped and flagged.
        tick(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("idle_result_overflow", overflow, 1);
        check("idle_result_not_valid", result_valid, 0);

        // Starting clears overflow; the 82nd result sets it again.
        run_job(1, -1);
        check("extra_result_overflow", overflow, 1);

        // Abort after pixel 50, then a clean job from weight 0.
        run_job(0, 51);
        check("abort_point_reached", p_acc, 51);
        do_reset();
        run_job(0, -1);

        for (int k = 0; k < 3; k++) run_job(2, -1);

`ifdef CONV_CTRL_TIMEOUT_EN
        run_job(3, -1);
        check("watchdog_timeout_flag", timeout, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
